// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO.
// Frames are start, DATA_BITS LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 ready_en;
  logic [CW-1:0]        bit_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 push, pop, full, bit_last, frame_end;

  // Handshake: a byte is taken on a rising edge where in_valid && in_ready;
  // in_ready depends only on occupancy, so a push at full is never taken.
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready  = ready_en && !full;
  assign push      = in_valid && in_ready;
  assign bit_last  = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign frame_end = (state == S_STOP) && bit_last && (bit_idx == 4'(STOP_BITS - 1));
  assign busy      = (state != S_IDLE) || (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx      = 1'b1;
    tx_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_last) state_n = S_DATA;
      end
      S_DATA: begin
        tx = shreg[0];
        if (bit_last && (bit_idx == 4'(DATA_BITS - 1)))
          state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = par_bit;
        if (bit_last) state_n = S_STOP;
      end
      S_STOP: begin
        if (frame_end) begin
          tx_done = 1'b1;
          // Back-to-back: next start bit follows the last stop bit directly.
          if (count != '0) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // bit_idx counts data bits in DATA and stop bits in STOP; cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_last) bit_cnt <= '0;
      else                             bit_cnt <= bit_cnt + 1'b1;

      if (state_n != state) bit_idx <= '0;
      else if (bit_last)    bit_idx <= bit_idx + 1'b1;

      if (pop) begin
        shreg   <= mem[rd_ptr];
        par_bit <= (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
      end else if (state == S_DATA && bit_last) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: single-frame vector table across four
// parameter sets, plus FIFO-full, back-to-back, pointer-wrap and reset sequences.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] val;
  logic [3:0] tx_v, done_v, busy_v, rdy_v;
  logic [2:0] cnt_v [4];

  int total = 0;
  int bad   = 0;
  int cur_t = 0;

  // Unit 0: 8N1, unit 1: 8E1, unit 2: 8O1, unit 3: 7N2; all CLKS_PER_BIT=4, depth 4.
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(val[0]), .in_ready(rdy_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_count(cnt_v[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(val[1]), .in_ready(rdy_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_count(cnt_v[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_valid(val[2]), .in_ready(rdy_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_count(cnt_v[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(din[6:0]), .in_valid(val[3]), .in_ready(rdy_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_count(cnt_v[3]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cur_t++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d act=%0d exp=%0d", name, cur_t, act, exp);
    end
  endtask

  // Line level for cycle c of an 8N1 frame carrying b (4 clocks per bit).
  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int k;
    k = c / 4;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  typedef struct {
    int          unit;
    logic [7:0]  data;
    logic [15:0] bits;   // bit i = i-th transmitted bit, start bit at index 0
    int          nbits;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{unit: 0, data: 8'hA5, bits: 16'b0000001101001010, nbits: 10};
    vecs[1] = '{unit: 0, data: 8'h3C, bits: 16'b0000001001111000, nbits: 10};
    vecs[2] = '{unit: 1, data: 8'h07, bits: 16'b0000011000001110, nbits: 11};
    vecs[3] = '{unit: 2, data: 8'h07, bits: 16'b0000010000001110, nbits: 11};
    vecs[4] = '{unit: 1, data: 8'hFF, bits: 16'b0000010111111110, nbits: 11};
    vecs[5] = '{unit: 2, data: 8'h80, bits: 16'b0000010100000000, nbits: 11};
    vecs[6] = '{unit: 3, data: 8'h55, bits: 16'b0000001110101010, nbits: 10};
    vecs[7] = '{unit: 3, data: 8'h7F, bits: 16'b0000001111111110, nbits: 10};

    rst_n = 1'b0;
    din   = 8'h00;
    val   = 4'b0000;

    // Reset state, checked before any clock edge and again with clocks running
    #3;
    for (int u = 0; u < 4; u++) begin
      chk("rst_tx",   tx_v[u],   1);
      chk("rst_busy", busy_v[u], 0);
      chk("rst_done", done_v[u], 0);
      chk("rst_rdy",  rdy_v[u],  0);
      chk("rst_cnt",  cnt_v[u],  0);
    end
    tick();
    tick();
    chk("rst_rdy_clk", rdy_v[0], 0);
    chk("rst_tx_clk",  tx_v[0],  1);
    #2 rst_n = 1'b1;
    #1 chk("rdy_pre_edge", rdy_v[0], 0);
    tick();
    for (int u = 0; u < 4; u++) chk("rdy_after_rel", rdy_v[u], 1);

    // Single-frame vector table
    for (int i = 0; i < 8; i++) begin
      int len;
      len = vecs[i].nbits * 4;
      din = vecs[i].data;
      val[vecs[i].unit] = 1'b1;
      tick();
      val = 4'b0000;
      chk("vec_cnt1", cnt_v[vecs[i].unit], 1);
      chk("vec_idle_tx", tx_v[vecs[i].unit], 1);
      tick();
      for (int c = 0; c < len; c++) begin
        chk($sformatf("vec%0d_tx", i), tx_v[vecs[i].unit], vecs[i].bits[c/4]);
        chk($sformatf("vec%0d_done", i), done_v[vecs[i].unit], (c == len - 1) ? 1 : 0);
        chk($sformatf("vec%0d_busy", i), busy_v[vecs[i].unit], 1);
        tick();
      end
      chk($sformatf("vec%0d_busy_end", i), busy_v[vecs[i].unit], 0);
      chk($sformatf("vec%0d_tx_end", i), tx_v[vecs[i].unit], 1);
      chk($sformatf("vec%0d_done_end", i), done_v[vecs[i].unit], 0);
    end

    // in_valid held for 8 cycles into an idle depth-4 FIFO: 5 accepted, back-to-back frames
    begin
      int acc;
      acc = 0;
      for (int t = 0; t <= 202; t++) begin
        if (t < 8) begin
          din = 8'h10 + 8'(t);
          val[0] = 1'b1;
          if (rdy_v[0]) acc++;
        end else begin
          val[0] = 1'b0;
        end
        if (t <= 42)
          chk("full_rdy", rdy_v[0], (t < 5 || t == 42) ? 1 : 0);
        if (t == 7) chk("full_cnt", cnt_v[0], 4);
        if (t >= 2 && t < 202) begin
          chk("b2b_tx", tx_v[0], exp_tx(8'h10 + 8'((t - 2) / 40), (t - 2) % 40));
          chk("b2b_done", done_v[0], (((t - 2) % 40) == 39) ? 1 : 0);
        end
        if (t == 202) begin
          chk("b2b_busy_end", busy_v[0], 0);
          chk("b2b_tx_end", tx_v[0], 1);
        end
        tick();
      end
      chk("full_accepted", acc, 5);
    end

    // Push and pop in the same cycle at count 2, with pointers wrapping
    for (int t = 0; t <= 162; t++) begin
      val[0] = 1'b0;
      if (t < 3) begin
        din = 8'h31 + 8'(t);
        val[0] = 1'b1;
      end
      if (t == 41) begin
        din = 8'h34;
        val[0] = 1'b1;
        chk("pp_rdy", rdy_v[0], 1);
      end
      if (t == 41 || t == 42) chk("pp_cnt", cnt_v[0], 2);
      if (t >= 2 && t < 162)
        chk("pp_tx", tx_v[0], exp_tx(8'h31 + 8'((t - 2) / 40), (t - 2) % 40));
      if (t == 162) chk("pp_busy_end", busy_v[0], 0);
      tick();
    end
    val[0] = 1'b0;

    // Reset during data bit 3 with two bytes still queued
    for (int t = 0; t < 19; t++) begin
      val[0] = 1'b0;
      if (t < 3) begin
        din = 8'h00 + 8'(t * 17);
        val[0] = 1'b1;
      end
      tick();
    end
    val[0] = 1'b0;
    chk("mid_tx_low", tx_v[0], 0);
    chk("mid_cnt", cnt_v[0], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx",   tx_v[0],   1);
    chk("ar_cnt",  cnt_v[0],  0);
    chk("ar_busy", busy_v[0], 0);
    chk("ar_rdy",  rdy_v[0],  0);
    chk("ar_done", done_v[0], 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    #1 chk("ar_rdy_pre", rdy_v[0], 0);
    tick();
    chk("ar_rdy_post", rdy_v[0], 1);
    for (int t = 0; t < 60; t++) begin
      chk("ar_idle_tx", tx_v[0], 1);
      chk("ar_idle_busy", busy_v[0], 0);
      tick();
    end
    chk("ar_idle_cnt", cnt_v[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
